// File: rtl/vxe_txnreqa_arbiter_if.sv
// Request/response bundle between the vector-engine clients, the txn arbiter and the memory request path.
// Arbiter side uses the slave modport; the client/memory side uses master.
interface vxe_txnreqa_arbiter_if;
  logic [3:0]   i_req_vld;
  logic [3:0]   i_req_rnw;
  logic [147:0] i_req_addr;
  logic [3:0]   o_req_rdy;
  logic         o_txn_vld;
  logic [43:0]  o_txn;
  logic         i_txn_rdy;
  logic         i_rsp_vld;
  logic [5:0]   i_rsp_txnid;
  logic         o_busy;
  logic         o_err;

  modport slave (
    input  i_req_vld, i_req_rnw, i_req_addr, i_txn_rdy, i_rsp_vld, i_rsp_txnid,
    output o_req_rdy, o_txn_vld, o_txn, o_busy, o_err
  );

  modport master (
    output i_req_vld, i_req_rnw, i_req_addr, i_txn_rdy, i_rsp_vld, i_rsp_txnid,
    input  o_req_rdy, o_txn_vld, o_txn, o_busy, o_err
  );
endinterface

// File: rtl/vxe_txnreqa_arbiter.sv
// Purpose: 4-way round-robin arbiter building {txnid, rnw, addr} request words with per-client outstanding limits.
// Latency: 1 cycle from o_req_rdy to o_txn_vld; one word per cycle when i_txn_rdy stays high.
// Backpressure: held word stalls all grants; VXE_TXNREQA_ARB_PRIO0_EN gives client 0 strict priority.
module vxe_txnreqa_arbiter #(
  parameter int MAX_OUTST = 8
) (
  input logic                  clk,
  input logic                  rst,
  vxe_txnreqa_arbiter_if.slave bus
);

  typedef struct packed {
    logic [1:0]  cid;
    logic [3:0]  seq;
    logic        rnw;
    logic [36:0] addr;
  } txn_t;

  localparam logic [4:0] CNT_MAX = 5'(MAX_OUTST);

  logic [1:0] rr;
  logic [4:0] cnt [4];
  logic [3:0] seq [4];
  txn_t       txn_q;
  logic       txn_vld_q;
  logic       err_q;

  logic       load;
  logic [3:0] elig;
  logic [3:0] cand;
  logic [3:0] gnt;
  logic       gnt_any;
  logic [1:0] gidx;
  logic [1:0] rsp_cid;
  logic [3:0] rsp_dec;

  assign rsp_cid = bus.i_rsp_txnid[5:4];

  always_comb begin
    load = ~txn_vld_q | bus.i_txn_rdy;
    for (int k = 0; k < 4; k++) begin
      elig[k]    = bus.i_req_vld[k] & (cnt[k] != CNT_MAX);
      rsp_dec[k] = bus.i_rsp_vld & (rsp_cid == 2'(k)) & (cnt[k] != 5'd0);
    end
    cand = elig;
`ifdef VXE_TXNREQA_ARB_PRIO0_EN
    if (elig[0]) cand = 4'b0001;
`endif
    // Reverse scan so the last hit is the first candidate at or after rr.
    gidx = rr;
    for (int i = 3; i >= 0; i--) begin
      if (cand[rr + 2'(i)]) gidx = rr + 2'(i);
    end
    gnt_any = load & (|cand);
    gnt     = gnt_any ? (4'b0001 << gidx) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr        <= 2'd0;
      txn_q     <= '0;
      txn_vld_q <= 1'b0;
      err_q     <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        cnt[k] <= 5'd0;
        seq[k] <= 4'd0;
      end
    end else begin
      if (load) txn_vld_q <= gnt_any;
      if (gnt_any) begin
        txn_q.cid  <= gidx;
        txn_q.seq  <= seq[gidx];
        txn_q.rnw  <= bus.i_req_rnw[gidx];
        txn_q.addr <= bus.i_req_addr[int'(gidx) * 37 +: 37];
        seq[gidx]  <= seq[gidx] + 4'd1;
`ifdef VXE_TXNREQA_ARB_PRIO0_EN
        if (gidx != 2'd0) rr <= gidx + 2'd1;
`else
        rr <= gidx + 2'd1;
`endif
      end
      // A completion against an empty counter is dropped and flagged.
      for (int k = 0; k < 4; k++) begin
        cnt[k] <= cnt[k] + {4'd0, gnt[k]} - {4'd0, rsp_dec[k]};
      end
      if (bus.i_rsp_vld && cnt[rsp_cid] == 5'd0) err_q <= 1'b1;
    end
  end

  assign bus.o_req_rdy = gnt;
  assign bus.o_txn_vld = txn_vld_q;
  assign bus.o_txn     = txn_q;
  assign bus.o_busy    = txn_vld_q | (|{cnt[0], cnt[1], cnt[2], cnt[3]});
  assign bus.o_err     = err_q;

endmodule

// File: tb/tb_vxe_txnreqa_arbiter.sv
// Bench for vxe_txnreqa_arbiter: directed scenarios plus random traffic against a queue-based reference model.
// Honours VXE_TXNREQA_ARB_PRIO0_EN when compiled with the same define as the design.
module tb_vxe_txnreqa_arbiter;
  localparam int MAX = 8;
`ifdef VXE_TXNREQA_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vxe_txnreqa_arbiter_if bus ();
  vxe_txnreqa_arbiter #(.MAX_OUTST(MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  // reference model
  int          m_cnt [4];
  int          m_seq [4];
  int          m_rr;
  bit          m_vld;
  logic [43:0] m_txn;
  bit          m_err;
  logic [5:0]  oq [$];

  // observations from the latest step
  logic [3:0]  obs_rdy;
  logic        obs_vld, obs_busy, obs_err;
  logic [43:0] obs_txn;
  int          last_g;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = 0;
      m_seq[k] = 0;
    end
    m_rr = 0; m_vld = 0; m_txn = '0; m_err = 0;
    oq.delete();
  endtask

  function automatic int m_pick(input logic [3:0] vld, input logic trdy);
    int c;
    if (m_vld && !trdy) return -1;
    if (PRIO && vld[0] && m_cnt[0] < MAX) return 0;
    for (int i = 0; i < 4; i++) begin
      c = (m_rr + i) % 4;
      if (vld[c] && m_cnt[c] < MAX && !(PRIO && c == 0)) return c;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_req_vld = '0; bus.i_req_rnw = '0; bus.i_req_addr = '0;
    bus.i_txn_rdy = 1'b0; bus.i_rsp_vld = 1'b0; bus.i_rsp_txnid = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    #1;
    chk("rst_txn_vld", 64'(bus.o_txn_vld), 64'd0);
    chk("rst_txn", 64'(bus.o_txn), 64'd0);
    chk("rst_err", 64'(bus.o_err), 64'd0);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
  endtask

  task automatic step(input logic [3:0] vld, input logic [3:0] rnw, input logic [147:0] addr,
                      input logic trdy, input logic rv, input logic [5:0] rid);
    int g;
    int c;
    int tot;
    bit found;
    @(negedge clk);
    bus.i_req_vld = vld; bus.i_req_rnw = rnw; bus.i_req_addr = addr;
    bus.i_txn_rdy = trdy; bus.i_rsp_vld = rv; bus.i_rsp_txnid = rid;
    #1;
    obs_rdy = bus.o_req_rdy; obs_vld = bus.o_txn_vld; obs_txn = bus.o_txn;
    obs_busy = bus.o_busy; obs_err = bus.o_err;
    g = m_pick(vld, trdy);
    last_g = g;
    tot = m_cnt[0] + m_cnt[1] + m_cnt[2] + m_cnt[3];
    chk("req_rdy", 64'(obs_rdy), (g >= 0) ? (64'd1 << g) : 64'd0);
    chk("txn_vld", 64'(obs_vld), 64'(m_vld));
    if (m_vld) chk("txn", 64'(obs_txn), 64'(m_txn));
    chk("busy", 64'(obs_busy), 64'(m_vld || tot > 0));
    chk("err", 64'(obs_err), 64'(m_err));
    if (rv) begin
      c = int'(rid[5:4]);
      if (m_cnt[c] == 0) m_err = 1;
      else begin
        m_cnt[c]--;
        found = 0;
        for (int i = 0; i < oq.size(); i++) begin
          if (!found && oq[i] == rid) begin
            oq.delete(i);
            found = 1;
          end
        end
      end
    end
    if (g >= 0) begin
      m_txn = {2'(g), 4'(m_seq[g]), rnw[g], addr[37*g +: 37]};
      m_vld = 1;
      oq.push_back({2'(g), 4'(m_seq[g])});
      m_seq[g] = (m_seq[g] + 1) % 16;
      m_cnt[g]++;
      if (!PRIO || g != 0) m_rr = (g + 1) % 4;
    end else if (!m_vld || trdy) begin
      m_vld = 0;
    end
    @(posedge clk);
  endtask

  logic [147:0] a;
  logic [159:0] rnd;
  logic [5:0]   rid;
  logic         rv;
  int           ng;
  int           k0;

  initial begin
    m_reset();
    last_g = -1;
    a = '0;
    do_reset();

    // single client 1: Id 0x10 then 0x11
    a[37 +: 37] = 37'h0_1234_5678;
    step(4'b0010, 4'b0010, a, 1'b1, 1'b0, 6'h0);
    chk("s1_rdy", 64'(obs_rdy), 64'b0010);
    step(4'b0010, 4'b0010, a, 1'b1, 1'b0, 6'h0);
    chk("s1_word", 64'(obs_txn), 64'({6'h10, 1'b1, 37'h0_1234_5678}));
    step(4'b0000, 4'b0000, a, 1'b1, 1'b0, 6'h0);
    chk("s1_id2", 64'(obs_txn[43:38]), 64'h11);

    // all four valid until saturated
    do_reset();
    ng = 0;
    for (int i = 0; i < 34; i++) begin
      step(4'b1111, 4'b0101, a, 1'b1, 1'b0, 6'h0);
      if (last_g >= 0) begin
        chk("s2_order", 64'(obs_rdy),
            64'd1 << (PRIO ? ((ng < 8) ? 0 : 1 + (ng - 8) % 3) : ng % 4));
        ng++;
      end
    end
    chk("s2_ngrant", 64'(ng), 64'd32);
    chk("s2_rdy0", 64'(obs_rdy), 64'd0);
    chk("s2_busy", 64'(obs_busy), 64'd1);

    // completion for 0x23 reopens exactly one slot for client 2
    step(4'b1111, 4'b0000, a, 1'b1, 1'b1, 6'h23);
    step(4'b1111, 4'b0000, a, 1'b1, 1'b0, 6'h0);
    chk("s3_regrant", 64'(obs_rdy), 64'b0100);
    step(4'b1111, 4'b0000, a, 1'b1, 1'b0, 6'h0);
    chk("s3_full", 64'(obs_rdy), 64'd0);

    // held word under backpressure
    do_reset();
    a = '0;
    a[36:0] = 37'h1F_0000_00AB;
    step(4'b0001, 4'b0001, a, 1'b1, 1'b0, 6'h0);
    for (int i = 0; i < 5; i++) begin
      step(4'b1001, 4'b1001, a, 1'b0, 1'b0, 6'h0);
      chk("s4_hold", 64'(obs_txn), 64'({6'h00, 1'b1, 37'h1F_0000_00AB}));
      chk("s4_rdy0", 64'(obs_rdy), 64'd0);
    end
    step(4'b1001, 4'b1001, a, 1'b1, 1'b0, 6'h0);
    chk("s4_release", 64'(obs_rdy), PRIO ? 64'b0001 : 64'b1000);

    // same-cycle grant and completion for client 0 at cnt 3
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b0001, 4'b0, a, 1'b1, 1'b0, 6'h0);
    step(4'b0001, 4'b0, a, 1'b1, 1'b1, 6'h00);
    chk("s5_grant", 64'(obs_rdy), 64'b0001);
    k0 = 0;
    for (int i = 0; i < 8; i++) begin
      step(4'b0001, 4'b0, a, 1'b1, 1'b0, 6'h0);
      if (obs_rdy == 4'b0001) k0++;
    end
    chk("s5_more", 64'(k0), 64'd5);
    step(4'b0000, 4'b0, a, 1'b1, 1'b1, 6'h30);
    step(4'b0000, 4'b0, a, 1'b1, 1'b0, 6'h0);
    chk("s5_err", 64'(obs_err), 64'd1);
    step(4'b0000, 4'b0, a, 1'b1, 1'b0, 6'h0);
    chk("s5_err_sticky", 64'(obs_err), 64'd1);

    // clients 0 and 2 contending
    do_reset();
    for (int i = 0; i < 18; i++) begin
      step(4'b0101, 4'b0, a, 1'b1, 1'b0, 6'h0);
      if (i < 16) chk("s6_order", 64'(obs_rdy),
                      PRIO ? ((i < 8) ? 64'b0001 : 64'b0100) : ((i % 2 == 0) ? 64'b0001 : 64'b0100));
      else chk("s6_done", 64'(obs_rdy), 64'd0);
    end

    // random traffic with a reset in the middle
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      rv  = 1'b0;
      rid = 6'h0;
      if (oq.size() > 0 && $urandom_range(0, 99) < 40) begin
        rv  = 1'b1;
        rid = oq[$urandom_range(0, oq.size() - 1)];
      end else if ($urandom_range(0, 99) < 3) begin
        for (int k = 0; k < 4; k++) begin
          if (!rv && m_cnt[k] == 0) begin
            rv  = 1'b1;
            rid = {2'(k), 4'($urandom_range(0, 15))};
          end
        end
      end
      step(4'($urandom), 4'($urandom), rnd[147:0], ($urandom_range(0, 99) < 70), rv, rid);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/vxe_txnreqa_arbiter.md
Name: vxe_txnreqa_arbiter

Overview:
- Round-robin arbiter that shares one address-only request channel among 4 requesters (client 0..3).
- Builds the 44-bit request word: txnid[5:0] at [43:38], rnw at [37], 37-bit upper address at [36:0].
- Generates transaction Ids and limits outstanding transactions per client.
- Sits between the vector engine's fetch/store clients and the memory interface request path, upstream of the request decoder.

Parameters:
- MAX_OUTST, 8, maximum outstanding transactions per client. Legal range 1..16.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_req_vld  input  4  per-client request valid
- i_req_rnw  input  4  per-client read(1)/write(0)
- i_req_addr  input  148  per-client address; client k uses [37k+36:37k]
- o_req_rdy  output  4  per-client accept, one-hot or zero
- o_txn_vld  output  1  request word valid
- o_txn  output  44  request word {txnid, rnw, addr}
- i_txn_rdy  input  1  downstream accepts o_txn
- i_rsp_vld  input  1  transaction completion strobe
- i_rsp_txnid  input  6  Id of the completed transaction
- o_busy  output  1  output valid or any transaction outstanding
- o_err  output  1  sticky: completion received for a client with zero outstanding

Behaviour:
- Reset:
  - o_txn_vld=0, o_txn=0, o_err=0.
  - Round-robin pointer rr=0.
  - Per-client sequence counters seq[k]=0; outstanding counters cnt[k]=0.
  - Reset mid-transfer discards the held word and all counts.
- Output slot:
  - Single registered slot. load = ~o_txn_vld | i_txn_rdy.
  - o_txn/o_txn_vld hold stable while o_txn_vld & ~i_txn_rdy.
- Eligibility: elig[k] = i_req_vld[k] & (cnt[k] != MAX_OUTST).
- Grant:
  - When load and elig != 0, grant the first eligible client scanning rr, rr+1, ... mod 4.
  - o_req_rdy = one-hot grant, combinational from i_req_vld and state.
  - Clients must not make vld depend on rdy.
  - Zero when load=0 or elig=0.
- On a grant to client g in cycle N:
  - Next cycle (N+1): o_txn = {g[1:0], seq[g][3:0], i_req_rnw[g], addr_g}, o_txn_vld=1.
  - seq[g] increments mod 16.
  - cnt[g] increments.
  - rr updates to (g+1) mod 4.
  - Latency: 1 cycle from accept to o_txn_vld.
- Back-to-back: grant on the same cycle o_txn is consumed (i_txn_rdy=1), giving full throughput of 1 word/cycle.
- No grant while load=1: o_txn_vld drops to 0 next cycle; o_txn may keep its last value.
- Completion:
  - i_rsp_vld decrements cnt[i_rsp_txnid[5:4]].
  - Grant and completion for the same client in the same cycle: count unchanged.
  - Completion when cnt=0: count stays 0 and o_err sets until reset.
- Id uniqueness: MAX_OUTST<=16 guarantees no two outstanding Ids of one client coincide.
- Counter widths: cnt is 5 bits; seq is 4 bits.
- o_busy = o_txn_vld | (|cnt[0..3]), combinational.

Optional Feature:
- Macro: VXE_TXNREQA_ARB_PRIO0_EN.
- Defined:
  - Client 0 has strict priority: if elig[0] and load, client 0 is granted regardless of rr.
  - rr updates only on grants to clients 1..3.
  - Clients 1..3 are round-robin among themselves.
- Undefined: pure 4-way round-robin as above.

Test Plan:
- Reset, then client 1 only: vld=1, rnw=1, addr=37'h0_1234_5678, i_txn_rdy=1.
  -> o_req_rdy=4'b0010 in cycle N; cycle N+1 o_txn_vld=1, o_txn[43:38]=6'h10, o_txn[37]=1, o_txn[36:0]=37'h0_1234_5678.
  -> Next grant to client 1 uses Id 6'h11.
- All 4 clients valid continuously, i_txn_rdy=1, no responses.
  -> Grant order 0,1,2,3,0,1,... one per cycle until each has 8 outstanding.
  -> Then o_req_rdy=0 and o_busy=1.
- Client 2 held at MAX_OUTST=8, then i_rsp_vld with txnid 6'h23.
  -> Exactly one further grant to client 2 next cycle; cnt[2] back to 8.
- Word held with i_txn_rdy=0 for 5 cycles while clients 0,3 valid.
  -> o_txn stable, o_req_rdy=0 throughout.
  -> On i_txn_rdy=1, grant client rr in the same cycle.
- Same-cycle grant and completion for client 0 at cnt=3.
  -> cnt stays 3.
  -> Completion for client 3 at cnt=0: o_err=1 and stays 1.
- With VXE_TXNREQA_ARB_PRIO0_EN, clients 0 and 2 always valid.
  -> Client 0 granted every cycle until cnt[0]=8, then client 2.
  -> Without the macro: alternates 0,2,0,2.
